// File: rtl/wb_daq_pkg.sv
// Shared DAQ datapath constants used by the aggregation, ADC and FIFO stages.
package wb_daq_pkg;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
endpackage : wb_daq_pkg

// File: rtl/wb_daq_fifo_if.sv
// Push/pop/status bundle of the DAQ sample FIFO; master = producer/reader side, slave = FIFO.
interface wb_daq_fifo_if
    import wb_daq_pkg::*;
#(
    parameter int dw = DW,
    parameter int aw = AW
);
    logic          push;
    logic [dw-1:0] data_in;
    logic          pop;
    logic [dw-1:0] data_out;
    logic          data_valid;
    logic          flush;
    logic          flags_clear;
    logic [aw:0]   threshold;
    logic [aw:0]   count;
    logic          full;
    logic          empty;
    logic          threshold_reached;
    logic          overflow;
    logic          underflow;

    modport master (
        output push, data_in, pop, flush, flags_clear, threshold,
        input  data_out, data_valid, count, full, empty,
               threshold_reached, overflow, underflow
    );

    modport slave (
        input  push, data_in, pop, flush, flags_clear, threshold,
        output data_out, data_valid, count, full, empty,
               threshold_reached, overflow, underflow
    );
endinterface : wb_daq_fifo_if

// File: rtl/wb_daq_fifo_ram.sv
// Simple dual-port RAM: synchronous write port, synchronous registered read port.
module wb_daq_fifo_ram #(
    parameter int dw = 32,
    parameter int aw = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [aw-1:0] i_waddr,
    input  logic [dw-1:0] i_wdata,
    input  logic          i_re,
    input  logic [aw-1:0] i_raddr,
    output logic [dw-1:0] o_rdata
);
    logic [dw-1:0] r_mem [2**aw];

    // NOTE: the array has no reset so it maps onto block RAM; occupancy, not contents, defines validity.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Same-address read and write return the old word, which the full push+pop case relies on.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end
endmodule : wb_daq_fifo_ram

// File: rtl/wb_daq_fifo.sv
// DAQ sample FIFO: pointer/occupancy control, threshold flag and sticky error flags around the RAM.
module wb_daq_fifo
    import wb_daq_pkg::*;
(
    input  logic          wb_clk,
    input  logic          wb_rst,
    wb_daq_fifo_if.slave  bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_data_valid;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_push_acc;
    logic          w_pop_acc;
    logic          w_ovf_evt;
    logic          w_unf_evt;
    logic [DW-1:0] w_rdata;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_pop_acc  = 1'b0;
        w_push_acc = 1'b0;
        w_ovf_evt  = 1'b0;
        w_unf_evt  = 1'b0;
        if (!bus.flush) begin
            w_pop_acc  = bus.pop && !w_empty;
            w_push_acc = bus.push && (!w_full || w_pop_acc);
            w_ovf_evt  = bus.push && !w_push_acc;
            w_unf_evt  = bus.pop && !w_pop_acc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_data_valid <= w_pop_acc;
            if (bus.flush) begin
                r_wp    <= '0;
                r_rp    <= '0;
                r_count <= '0;
            end else begin
                if (w_push_acc) r_wp <= r_wp + 1'b1;
                if (w_pop_acc)  r_rp <= r_rp + 1'b1;
                r_count <= r_count + (AW+1)'(w_push_acc) - (AW+1)'(w_pop_acc);
            end
            // An error event in the clearing cycle keeps its flag set.
            r_overflow  <= w_ovf_evt || (r_overflow  && !bus.flags_clear);
            r_underflow <= w_unf_evt || (r_underflow && !bus.flags_clear);
        end
    end

    wb_daq_fifo_ram #(.dw(DW), .aw(AW)) u_ram (
        .i_clk   (wb_clk),
        .i_rst   (wb_rst),
        .i_we    (w_push_acc),
        .i_waddr (r_wp),
        .i_wdata (bus.data_in),
        .i_re    (w_pop_acc),
        .i_raddr (r_rp),
        .o_rdata (w_rdata)
    );

    assign bus.data_out          = w_rdata;
    assign bus.data_valid        = r_data_valid;
    assign bus.count             = r_count;
    assign bus.full              = w_full;
    assign bus.empty             = w_empty;
    assign bus.threshold_reached = (bus.threshold != '0) && (r_count >= bus.threshold);
    assign bus.overflow          = r_overflow;
    assign bus.underflow         = r_underflow;
endmodule : wb_daq_fifo
